gray_frame_sequencer: RTL and testbench

- Frame-level controller for the grayscale core.
- Accepts a stream of RGB555 pixels over a valid/ready handshake, holds each pixel stable for the core, and drives the core's `start_i`/`finish_i` so one `PROCESSING` window spans exactly one frame.
- Re-aligns the core's gray output with valid, end-of-line and end-of-frame markers for the downstream Sobel line buffers.
- Sits between the pixel source and the grayscale core; the Sobel stage consumes its output side.

---
 rtl/gray_frame_sequencer_pkg.sv | 33 +++
 rtl/gray_seq_pixel_counter.sv | 60 ++++++
 rtl/gray_frame_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_gray_frame_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_frame_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// gray_frame_sequencer_pkg
//   Shared definitions for the grayscale frame sequencer and its pixel counter.
//
//   Contents:
//     MAX_PIXEL_BITS / PIXEL_WIDTH_OUT : RGB555 input width and gray output width
//     IMG_*_DEFAULT / TIMEOUT_*_DEFAULT: default frame geometry and idle limit
//     seq_state_t                      : 2-bit frame FSM state encoding
//     cnt_width()                      : counter width helper, never below 1 bit
// -----------------------------------------------------------------------------
package gray_frame_sequencer_pkg;

  localparam int MAX_PIXEL_BITS         = 15;
  localparam int PIXEL_WIDTH_OUT        = 8;

  localparam int IMG_WIDTH_DEFAULT      = 640;
  localparam int IMG_HEIGHT_DEFAULT     = 480;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // $clog2(1) is 0, which would give a zero-width counter for a one-line
  // frame; clamp to one bit so the counter always exists.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gray_seq_pixel_counter.sv
// -----------------------------------------------------------------------------
// gray_seq_pixel_counter
//   Column/line position tracker for one frame. The column counter wraps at
//   IMG_WIDTH-1 and each wrap advances the line counter. The decode outputs
//   describe the position of the pixel that the next advance will consume.
//
//   Ports:
//     clk_i      in   clock
//     nreset_i   in   asynchronous active-low reset
//     clear_i    in   return both counters to 0 (frame start)
//     advance_i  in   one pixel accepted this cycle
//     last_x_o   out  current position is the last column of a line
//     last_xy_o  out  current position is the last pixel of the frame
// -----------------------------------------------------------------------------
module gray_seq_pixel_counter
  import gray_frame_sequencer_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEFAULT,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEFAULT
) (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic clear_i,
  input  logic advance_i,
  output logic last_x_o,
  output logic last_xy_o
);

  localparam int XW = cnt_width(IMG_WIDTH);
  localparam int YW = cnt_width(IMG_HEIGHT);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0] x_cnt_reg;
  logic [YW-1:0] y_cnt_reg;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      x_cnt_reg <= '0;
      y_cnt_reg <= '0;
    end else if (clear_i) begin
      x_cnt_reg <= '0;
      y_cnt_reg <= '0;
    end else if (advance_i) begin
      if (x_cnt_reg == X_LAST) begin
        x_cnt_reg <= '0;
        // Wrapping the line counter too keeps it in range when IMG_HEIGHT
        // is not a power of two; the FSM leaves RUN on that pixel anyway.
        y_cnt_reg <= (y_cnt_reg == Y_LAST) ? '0 : y_cnt_reg + 1'b1;
      end else begin
        x_cnt_reg <= x_cnt_reg + 1'b1;
      end
    end
  end

  assign last_x_o  = (x_cnt_reg == X_LAST);
  assign last_xy_o = last_x_o && (y_cnt_reg == Y_LAST);

endmodule

// File: rtl/gray_frame_sequencer.sv
// -----------------------------------------------------------------------------
// gray_frame_sequencer
//   Frame-level controller for the grayscale core. Accepts RGB555 pixels over
//   valid/ready, holds the last accepted pixel steady for the core, frames one
//   core PROCESSING window per image with start/finish, and re-aligns the
//   core's gray output with valid/eol/eof markers for the Sobel line buffers.
//
//   Optional feature (compile-time macro GRAY_SEQ_TIMEOUT_EN):
//     defined   : RUN aborts to DRAIN after TIMEOUT_CYCLES consecutive cycles
//                 without an accept and raises the sticky timeout_o flag.
//     undefined : RUN waits indefinitely and timeout_o stays 0.
//
//   Ports:
//     clk_i          in   clock
//     nreset_i       in   asynchronous active-low reset (shared with the core)
//     frame_start_i  in   one-cycle frame request, honoured only in IDLE
//     s_px_i         in   RGB555 pixel from the source
//     s_valid_i      in   source pixel valid
//     s_ready_o      out  sequencer accepts s_px_i (RUN only)
//     core_px_o      out  held pixel to the core
//     core_start_o   out  core start, first RUN cycle only
//     core_finish_o  out  core finish, second DRAIN cycle
//     core_gray_i    in   gray pixel from the core
//     m_gray_o       out  gray pixel to the Sobel stage (equals core_gray_i)
//     m_valid_o      out  m_gray_o valid, two cycles after the accept
//     m_eol_o        out  last pixel of a line, qualified by m_valid_o
//     m_eof_o        out  last pixel of the frame, qualified by m_valid_o
//     busy_o         out  FSM not in IDLE
//     frame_done_o   out  one-cycle pulse in DONE
//     timeout_o      out  sticky abort flag, cleared by the next frame start
// -----------------------------------------------------------------------------
module gray_frame_sequencer
  import gray_frame_sequencer_pkg::*;
#(
  parameter int IMG_WIDTH      = IMG_WIDTH_DEFAULT,
  parameter int IMG_HEIGHT     = IMG_HEIGHT_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       nreset_i,
  input  logic                       frame_start_i,
  input  logic [MAX_PIXEL_BITS-1:0]  s_px_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  output logic [MAX_PIXEL_BITS-1:0]  core_px_o,
  output logic                       core_start_o,
  output logic                       core_finish_o,
  input  logic [PIXEL_WIDTH_OUT-1:0] core_gray_i,
  output logic [PIXEL_WIDTH_OUT-1:0] m_gray_o,
  output logic                       m_valid_o,
  output logic                       m_eol_o,
  output logic                       m_eof_o,
  output logic                       busy_o,
  output logic                       frame_done_o,
  output logic                       timeout_o
);

  seq_state_t                state_reg;
  logic                      drain_cnt_reg;
  logic                      s_ready_reg;
  logic                      busy_reg;
  logic                      core_start_reg;
  logic                      core_finish_reg;
  logic                      frame_done_reg;
  logic                      timeout_reg;
  logic [MAX_PIXEL_BITS-1:0] px_reg;

  // Marker pipe: stage 1 lines up with the core sampling px_reg, stage 2 with
  // the core's registered gray output.
  logic valid_s1_reg, eol_s1_reg, eof_s1_reg;
  logic valid_s2_reg, eol_s2_reg, eof_s2_reg;

  logic accept;
  logic frame_begin;
  logic last_x;
  logic last_xy;
  logic timeout_hit;

  // s_ready_reg is only ever high in RUN, so an accept implies RUN.
  assign accept      = s_valid_i && s_ready_reg;
  assign frame_begin = (state_reg == IDLE) && frame_start_i;

  gray_seq_pixel_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_pixel_counter (
    .clk_i     (clk_i),
    .nreset_i  (nreset_i),
    .clear_i   (frame_begin),
    .advance_i (accept),
    .last_x_o  (last_x),
    .last_xy_o (last_xy)
  );

`ifdef GRAY_SEQ_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES);

  logic [IW-1:0] idle_cnt_reg;

  // An accept in the limit cycle wins over the abort so no pixel is lost.
  assign timeout_hit = (state_reg == RUN) && !accept && (idle_cnt_reg == IDLE_LIMIT);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      idle_cnt_reg <= '0;
    end else if ((state_reg != RUN) || accept) begin
      idle_cnt_reg <= '0;
    end else if (!timeout_hit) begin
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end
`else
  logic timeout_unused;

  assign timeout_hit    = 1'b0;
  assign timeout_unused = |TIMEOUT_CYCLES;
`endif

  // Frame FSM. Every control output is a register updated together with the
  // state, so each one is valid in exactly the state it belongs to.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_reg       <= IDLE;
      drain_cnt_reg   <= 1'b0;
      s_ready_reg     <= 1'b0;
      busy_reg        <= 1'b0;
      core_start_reg  <= 1'b0;
      core_finish_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      core_start_reg  <= 1'b0;
      core_finish_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (frame_start_i) begin
            state_reg      <= RUN;
            s_ready_reg    <= 1'b1;
            busy_reg       <= 1'b1;
            core_start_reg <= 1'b1;
            timeout_reg    <= 1'b0;
          end
        end
        RUN: begin
          if ((accept && last_xy) || timeout_hit) begin
            state_reg     <= DRAIN;
            s_ready_reg   <= 1'b0;
            drain_cnt_reg <= 1'b0;
            if (timeout_hit) begin
              timeout_reg <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // Two cycles: the last pixel reaches the core register in the
          // first, and finish coincides with its gray output in the second.
          if (!drain_cnt_reg) begin
            drain_cnt_reg   <= 1'b1;
            core_finish_reg <= 1'b1;
          end else begin
            state_reg      <= DONE;
            frame_done_reg <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Pixel hold and marker pipe.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      px_reg       <= '0;
      valid_s1_reg <= 1'b0;
      eol_s1_reg   <= 1'b0;
      eof_s1_reg   <= 1'b0;
      valid_s2_reg <= 1'b0;
      eol_s2_reg   <= 1'b0;
      eof_s2_reg   <= 1'b0;
    end else begin
      if (accept) begin
        px_reg <= s_px_i;
      end
      valid_s1_reg <= accept;
      eol_s1_reg   <= accept && last_x;
      eof_s1_reg   <= accept && last_xy;
      valid_s2_reg <= valid_s1_reg;
      eol_s2_reg   <= eol_s1_reg;
      eof_s2_reg   <= eof_s1_reg;
    end
  end

  assign s_ready_o     = s_ready_reg;
  assign core_px_o     = px_reg;
  assign core_start_o  = core_start_reg;
  assign core_finish_o = core_finish_reg;
  assign m_gray_o      = core_gray_i;
  assign m_valid_o     = valid_s2_reg;
  assign m_eol_o       = eol_s2_reg;
  assign m_eof_o       = eof_s2_reg;
  assign busy_o        = busy_reg;
  assign frame_done_o  = frame_done_reg;
  assign timeout_o     = timeout_reg;

endmodule

// File: tb/tb_gray_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gray_frame_sequencer
//   Drives 4x2 frames through the sequencer with a behavioural grayscale core
//   attached, and checks every output cycle against a scoreboard built from
//   accept order (pixel index -> eol/eof, accept cycle + 2 -> output cycle).
// -----------------------------------------------------------------------------
module tb_gray_frame_sequencer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NPX = W * H;

  logic        clk_i;
  logic        nreset_i;
  logic        frame_start_i;
  logic [14:0] s_px_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [14:0] core_px_o;
  logic        core_start_o;
  logic        core_finish_o;
  logic [7:0]  core_gray;
  logic [7:0]  m_gray_o;
  logic        m_valid_o;
  logic        m_eol_o;
  logic        m_eof_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        timeout_o;

  gray_frame_sequencer #(
    .IMG_WIDTH      (W),
    .IMG_HEIGHT     (H),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i         (clk_i),
    .nreset_i      (nreset_i),
    .frame_start_i (frame_start_i),
    .s_px_i        (s_px_i),
    .s_valid_i     (s_valid_i),
    .s_ready_o     (s_ready_o),
    .core_px_o     (core_px_o),
    .core_start_o  (core_start_o),
    .core_finish_o (core_finish_o),
    .core_gray_i   (core_gray),
    .m_gray_o      (m_gray_o),
    .m_valid_o     (m_valid_o),
    .m_eol_o       (m_eol_o),
    .m_eof_o       (m_eof_o),
    .busy_o        (busy_o),
    .frame_done_o  (frame_done_o),
    .timeout_o     (timeout_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Luma of an RGB555 pixel with 5-bit channels scaled to 8 bits.
  function automatic logic [7:0] gray_of(input logic [14:0] px);
    int r, g, b;
    r = int'(px[14:10]) << 3;
    g = int'(px[9:5]) << 3;
    b = int'(px[4:0]) << 3;
    return 8'((r * 63 + g * 160 + b * 32) >> 8);
  endfunction

  // Behavioural core: one register stage, re-samples its input every cycle.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) core_gray <= 8'h00;
    else           core_gray <= gray_of(core_px_o);
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int k      = 0;
  int fin_cyc  = -1;
  int done_cyc = -1;
  bit mon_en = 1'b0;
  bit chk_fd = 1'b1;
  logic [14:0] held = '0;

  typedef struct {
    int         cyc;
    logic [7:0] gray;
    logic       eol;
    logic       eof;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  // Scoreboard monitor, sampling mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!nreset_i) begin
        exp_q.delete();
        held     = '0;
        fin_cyc  = -1;
        done_cyc = -1;
      end else if (mon_en) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          chk("out_valid", 32'(m_valid_o), 1);
          chk("out_gray", 32'(m_gray_o), 32'(e.gray));
          chk("out_eol", 32'(m_eol_o), 32'(e.eol));
          chk("out_eof", 32'(m_eof_o), 32'(e.eof));
        end else begin
          chk("out_idle", 32'(m_valid_o), 0);
        end
        chk("core_px_hold", 32'(core_px_o), 32'(held));
        if (chk_fd) begin
          chk("core_finish", 32'(core_finish_o), 32'(cyc == fin_cyc));
          chk("frame_done", 32'(frame_done_o), 32'(cyc == done_cyc));
        end
        if (s_valid_i && s_ready_o) begin
          e.cyc  = cyc + 2;
          e.gray = gray_of(s_px_i);
          e.eol  = ((k % W) == W - 1);
          e.eof  = (k == NPX - 1);
          if (e.eof) begin
            fin_cyc  = cyc + 2;
            done_cyc = cyc + 3;
          end
          exp_q.push_back(e);
          held = s_px_i;
          k++;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"},  32'(s_ready_o), 0);
    chk({tag, "_px"},     32'(core_px_o), 0);
    chk({tag, "_start"},  32'(core_start_o), 0);
    chk({tag, "_finish"}, 32'(core_finish_o), 0);
    chk({tag, "_valid"},  32'(m_valid_o), 0);
    chk({tag, "_eol"},    32'(m_eol_o), 0);
    chk({tag, "_eof"},    32'(m_eof_o), 0);
    chk({tag, "_busy"},   32'(busy_o), 0);
    chk({tag, "_done"},   32'(frame_done_o), 0);
    chk({tag, "_tmo"},    32'(timeout_o), 0);
  endtask

  // Called in IDLE, 1 time unit after a rising edge.
  task automatic start_frame(input bit fd_checks);
    frame_start_i = 1'b1;
    k      = 0;
    chk_fd = fd_checks;
    @(posedge clk_i); #1;
    frame_start_i = 1'b0;
    chk("start_pulse", 32'(core_start_o), 1);
    chk("start_busy", 32'(busy_o), 1);
    chk("start_ready", 32'(s_ready_o), 1);
    chk("start_tmo_clear", 32'(timeout_o), 0);
  endtask

  // mode 0: back-to-back 0x7FFF; 1: valid 1-0-1-0; 2: random valid/pixels;
  // 3: red pixel then a stall; 4: random plus ignored frame_start pulses.
  // abort_after > 0 pulls nreset_i low after that many accepts.
  task automatic run_frame(input int mode, input int abort_after);
    int cnt = 0;
    int iter = 0;
    bit acc;
    start_frame(1'b1);
    while (cnt < NPX && iter < 200) begin
      if (iter == 1) chk("start_once", 32'(core_start_o), 0);
      if (mode == 3 && iter == 2) begin
        chk("red_valid", 32'(m_valid_o), 1);
        chk("red_gray", 32'(m_gray_o), 32'h3D);
      end
      if (mode == 3 && iter == 3) chk("red_hold", 32'(core_px_o), 32'h7C00);
      frame_start_i = (mode == 4 && iter == 3);
      case (mode)
        0: begin s_valid_i = 1'b1; s_px_i = 15'h7FFF; end
        1: begin s_valid_i = (iter % 2 == 0); s_px_i = 15'($urandom_range(0, 32767)); end
        3: begin
          s_valid_i = (iter == 0) || (iter > 3 && $urandom_range(0, 3) != 0);
          s_px_i    = (iter == 0) ? 15'h7C00 : 15'($urandom_range(0, 32767));
        end
        default: begin s_valid_i = ($urandom_range(0, 3) != 0); s_px_i = 15'($urandom_range(0, 32767)); end
      endcase
      @(negedge clk_i);
      acc = s_valid_i && s_ready_o;
      @(posedge clk_i); #1;
      if (acc) cnt++;
      iter++;
      if (abort_after > 0 && cnt == abort_after) begin
        frame_start_i = 1'b0;
        s_valid_i     = 1'b0;
        nreset_i      = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk_i); #1;
        nreset_i = 1'b1;
        @(posedge clk_i); #1;
        $display("frame mode=%0d aborted after %0d accepts", mode, cnt);
        return;
      end
    end
    frame_start_i = 1'b0;
    s_valid_i     = 1'b0;
    chk("px_count", cnt, NPX);
    // t+1: first DRAIN cycle
    chk("ready_drop", 32'(s_ready_o), 0);
    chk("busy_drain", 32'(busy_o), 1);
    if (mode == 4) frame_start_i = 1'b1;
    @(posedge clk_i); #1;
    // t+2: second DRAIN cycle, last pixel out
    frame_start_i = 1'b0;
    chk("last_valid", 32'(m_valid_o), 1);
    chk("last_eof", 32'(m_eof_o), 1);
    chk("last_finish", 32'(core_finish_o), 1);
    chk("drain_ready", 32'(s_ready_o), 0);
    if (mode == 0) chk("white_gray", 32'(m_gray_o), 32'hF7);
    @(posedge clk_i); #1;
    // t+3: DONE
    chk("done_pulse", 32'(frame_done_o), 1);
    chk("done_finish_low", 32'(core_finish_o), 0);
    chk("done_busy", 32'(busy_o), 1);
    if (mode == 4) frame_start_i = 1'b1;
    @(posedge clk_i); #1;
    // t+4: IDLE
    frame_start_i = 1'b0;
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_done_low", 32'(frame_done_o), 0);
    @(posedge clk_i); #1;
    chk("restart_ignored", 32'(busy_o), 0);
    chk("idle_ready", 32'(s_ready_o), 0);
    $display("frame mode=%0d complete: %0d pixels in %0d cycles", mode, cnt, iter);
  endtask

  initial begin
    nreset_i      = 1'b0;
    frame_start_i = 1'b0;
    s_valid_i     = 1'b0;
    s_px_i        = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    nreset_i = 1'b1;
    mon_en   = 1'b1;
    @(posedge clk_i); #1;

    run_frame(0, 0);
    run_frame(3, 0);
    run_frame(1, 0);
    run_frame(4, 0);
    run_frame(2, 3);
    run_frame(2, 0);
    for (int i = 0; i < 4; i++) run_frame(2, 0);
    for (int i = 0; i < 2; i++) run_frame(4, 0);

`ifdef GRAY_SEQ_TIMEOUT_EN
    begin
      bit saw_drain = 1'b0;
      bit saw_done  = 1'b0;
      start_frame(1'b0);
      for (int i = 0; i < 2; i++) begin
        s_valid_i = 1'b1;
        s_px_i    = 15'($urandom_range(0, 32767));
        @(posedge clk_i); #1;
      end
      s_valid_i = 1'b0;
      for (int i = 0; i < 40 && !saw_done; i++) begin
        @(posedge clk_i); #1;
        if (busy_o && !s_ready_o) saw_drain = 1'b1;
        if (frame_done_o) saw_done = 1'b1;
      end
      chk("tmo_drain", 32'(saw_drain), 1);
      chk("tmo_done", 32'(saw_done), 1);
      chk("tmo_flag", 32'(timeout_o), 1);
      @(posedge clk_i); #1;
      chk("tmo_idle", 32'(busy_o), 0);
      chk("tmo_sticky", 32'(timeout_o), 1);
      $display("timeout frame: drain=%0d done=%0d", saw_drain, saw_done);
      run_frame(2, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
